// File: rtl/minigame_switch_match.sv
// minigame_switch_match
//   Wake-up minigame run while the alarm logic holds `enable` high. Plays
//   NUM_ROUNDS rounds. Each round lights one pseudo-random LED. The player
//   scores the round by setting exactly the matching switch and holding it
//   for HOLD_TICKS cycles before ROUND_TICKS cycles run out. A blank gap of
//   GAP_TICKS cycles separates rounds.
//
// Ports
//   MCLK    in   board clock
//   RESET   in   synchronous active-high reset
//   enable  in   game runs while high; a rising edge starts a game
//   SPDT    in   [9:0] switches, bit i pairs with LED[i]
//   seed    in   [3:0] LFSR seed
//   done    out  high from game end until enable drops
//   score   out  [3:0] rounds won; valid while done=1
//   LED     out  [9:0] one-hot target, 0 outside a round
//
// Build option
//   MINIGAME_PENALTY_EN : any switch set outside the lit LED ends the round
//                         immediately as a miss.
module minigame_switch_match #(
  parameter int NUM_ROUNDS  = 4,
  parameter int ROUND_TICKS = 500_000_000,
  parameter int HOLD_TICKS  = 1_000_000,
  parameter int GAP_TICKS   = 50_000_000
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       enable,
  input  logic [9:0] SPDT,
  input  logic [3:0] seed,
  output logic       done,
  output logic [3:0] score,
  output logic [9:0] LED
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUND  = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // One timer serves both the round and the gap, so size it for the longer.
  localparam int TMAX = (ROUND_TICKS > GAP_TICKS) ? ROUND_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int HW   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [TW-1:0] ROUND_LAST = TW'(ROUND_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
  localparam logic [3:0]    ROUNDS_N   = 4'(NUM_ROUNDS);
  localparam logic [3:0]    ROUNDS_END = 4'(NUM_ROUNDS - 1);

  logic [1:0]    state;
  logic          enable_d;
  logic [7:0]    lfsr;
  logic [3:0]    round_cnt;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold;

  logic       match;
  logic       hit;
  logic       timeout;
  logic       penalty;
  logic [7:0] lfsr_next;

  // Fold the 4-bit LFSR slice onto 10 LEDs.
  function automatic logic [9:0] target_led(input logic [3:0] t);
    logic [3:0] idx;
    idx = (t >= 4'd10) ? t - 4'd10 : t;
    return 10'd1 << idx;
  endfunction

  assign match     = (SPDT == LED);
  assign hit       = match && (hold == HOLD_LAST);
  assign timeout   = (timer == ROUND_LAST);
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

`ifdef MINIGAME_PENALTY_EN
  assign penalty = |(SPDT & ~LED);
`else
  assign penalty = 1'b0;
`endif

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state     <= IDLE;
      // Reset as if enable was already high: a game needs a genuine low->high.
      enable_d  <= 1'b1;
      lfsr      <= 8'h01;
      round_cnt <= '0;
      timer     <= '0;
      hold      <= '0;
      score     <= '0;
      done      <= 1'b0;
      LED       <= '0;
    end else begin
      enable_d <= enable;
      case (state)
        IDLE: begin
          if (enable && !enable_d) begin
            // {seed,~seed} always has set bits, so the LFSR never locks up.
            lfsr      <= {seed, ~seed};
            score     <= '0;
            round_cnt <= '0;
            timer     <= '0;
            hold      <= '0;
            LED       <= target_led(~seed);
            state     <= ROUND;
          end
        end

        ROUND: begin
          if (!enable) begin
            // Abort outranks any hit/miss landing on the same cycle.
            state <= IDLE;
            LED   <= '0;
            timer <= '0;
            hold  <= '0;
          end else if (hit || timeout || penalty) begin
            if (hit && (score != ROUNDS_N))
              score <= score + 1'b1;
            LED       <= '0;
            lfsr      <= lfsr_next;
            round_cnt <= round_cnt + 1'b1;
            timer     <= '0;
            hold      <= '0;
            if (round_cnt == ROUNDS_END) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else begin
            timer <= timer + 1'b1;
            hold  <= match ? hold + 1'b1 : '0;
          end
        end

        GAP: begin
          if (!enable) begin
            state <= IDLE;
            LED   <= '0;
            timer <= '0;
          end else if (timer == GAP_LAST) begin
            timer <= '0;
            LED   <= target_led(lfsr[3:0]);
            state <= ROUND;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        FINISH: begin
          if (!enable) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
